if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch unit that produces the pc_i/inst_i stream consumed by the decode stage.
- Fetches each 32-bit instruction as four byte reads, little-endian, through the byte-wide memory arbiter port.
- Holds the word while decode raises a stall; flushes and redirects on a branch/jump from execute.
- Sits between the memory controller and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- NOP_INST, 32'h00000013, value driven on inst_o when inst_valid_o is low.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global ready; low freezes all state.
- stall_i  in  1  downstream cannot accept (decode stall or load hazard).
- br_flag_i  in  1  redirect request from execute.
- br_target_i  in  32  redirect PC, valid when br_flag_i=1.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  32  byte address of the request.
- mem_grant_i  in  1  arbiter accepted the request this cycle.
- mem_rdata_i  in  8  read byte, valid the cycle after a grant.
- pc_o  out  32  PC of the presented instruction.
- inst_o  out  32  presented instruction.
- inst_valid_o  out  1  pc_o/inst_o valid.

Behaviour:
- Clock/reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state=FETCH, fetch_pc=RESET_PC, issue_cnt=0, recv_cnt=0.
  - pc_o=RESET_PC, inst_o=NOP_INST, inst_valid_o=0, mem_req_o=0.
  - Reset mid-fetch drops all in-flight bytes.
- rdy=0: no register changes. mem_req_o=0. The memory side holds mem_rdata_i stable until rdy returns.
- States:
  - FETCH (issuing/collecting).
  - OUT (word presented).
- Request logic:
  - mem_req_o = (state==FETCH) & (issue_cnt<4) & rdy & !br_flag_i.
  - mem_addr_o = fetch_pc + issue_cnt, modulo 2^32; the low 2 bits of fetch_pc may be nonzero.
  - Grant: issue_cnt increments. No grant: request and address are held unchanged.
- Byte collection:
  - A grant at cycle t returns mem_rdata_i at t+1.
  - The byte is written to buffer bits [8*recv_cnt+7 : 8*recv_cnt], then recv_cnt increments.
- Transition FETCH->OUT when the 4th byte is captured. Registered: pc_o<=fetch_pc, inst_o<=assembled word with the 4th byte inserted, inst_valid_o<=1.
- Latency: with continuous grant, bytes are issued at cycles 0..3, the last byte returns at cycle 4, and inst_valid_o=1 at cycle 5.
- OUT state:
  - stall_i=1: pc_o, inst_o and inst_valid_o hold.
  - stall_i=0: the word is accepted this cycle. Next cycle: inst_valid_o=0, inst_o=NOP_INST, fetch_pc+=4, counters cleared, state=FETCH.
  - Throughput is 1 instruction per 6 cycles with no stall.
- Branch (br_flag_i=1 and rdy=1), highest priority, in any state:
  - Next cycle: fetch_pc=br_target_i, issue_cnt=recv_cnt=0, state=FETCH, inst_valid_o=0, inst_o=NOP_INST.
  - The byte returning in the branch cycle is discarded.
  - No request is issued in the branch cycle.
  - Branch beats stall_i and beats a simultaneous 4th-byte capture, which is discarded.
- Invariants:
  - recv_cnt <= issue_cnt <= 4.
  - inst_valid_o=1 only in OUT.
  - Never more than one byte in flight per cycle.

Test Plan:
- Reset:
  - Stimulus: assert rst, release; memory holds 0x93,0x00,0x10,0x00 at addresses 0..3; grant always 1.
  - Required: mem_addr_o 0,1,2,3 on cycles 0..3; inst_valid_o=1 at cycle 5 with pc_o=0, inst_o=32'h00100093; next fetch starts at address 4.
- Grant stall:
  - Stimulus: mem_grant_i low for 3 cycles while addr=2.
  - Required: mem_addr_o stays 2 and mem_req_o stays 1; valid is delayed 3 cycles; word is still correct.
- Downstream stall:
  - Stimulus: stall_i=1 for 4 cycles while in OUT.
  - Required: pc_o/inst_o/inst_valid_o constant for 4 cycles; after release, exactly one acceptance; next mem_addr_o = pc+4.
- Branch mid-fetch:
  - Stimulus: br_flag_i=1, br_target_i=0x100, after 2 bytes of word at 0x8 were granted.
  - Required: no request in the branch cycle; next addresses 0x100..0x103; the result pc_o=0x100 contains only new bytes.
- Branch vs stall/completion:
  - Stimulus: br_flag_i with stall_i=1 in OUT; separately, br_flag_i in the 4th-byte capture cycle.
  - Required: inst_valid_o=0 next cycle and fetch from target in both cases.
- rdy/reset:
  - Stimulus: rdy=0 for 5 cycles mid-fetch; separately, async rst pulse mid-fetch.
  - Required: rdy low gives no state change, mem_req_o=0, and the fetch resumes with a correct word. rst immediately gives inst_valid_o=0, pc restarted at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four little-endian
// byte reads through the byte-wide arbiter port and presents it to decode.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_i,
    input  logic        br_flag_i,
    input  logic [31:0] br_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_OUT   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [2:0]  r_issue_cnt;
    logic [2:0]  r_recv_cnt;
    logic        r_pending;
    logic [23:0] r_buf;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;

    logic        w_req;
    logic        w_grant;
    logic        w_cap;
    logic        w_last;
    logic        w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_grant     = 1'b0;
        w_cap       = 1'b0;
        w_last      = 1'b0;
        w_accept    = 1'b0;
        if (rdy && !rst) begin
            if (br_flag_i) begin
                w_state_nxt = S_FETCH;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        w_req   = (r_issue_cnt < 3'd4);
                        w_grant = w_req & mem_grant_i;
                        w_cap   = r_pending;
                        if (r_pending && (r_recv_cnt == 3'd3)) begin
                            w_last      = 1'b1;
                            w_state_nxt = S_OUT;
                        end
                    end
                    S_OUT: begin
                        if (!stall_i) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                    end
                    default: w_state_nxt = S_FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect overrides everything: the byte returning this cycle is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_issue_cnt <= 3'd0;
            r_recv_cnt  <= 3'd0;
            r_pending   <= 1'b0;
            r_pc        <= RESET_PC;
            r_inst      <= NOP_INST;
            r_valid     <= 1'b0;
        end else if (rdy) begin
            if (br_flag_i) begin
                r_fetch_pc  <= br_target_i;
                r_issue_cnt <= 3'd0;
                r_recv_cnt  <= 3'd0;
                r_pending   <= 1'b0;
                r_inst      <= NOP_INST;
                r_valid     <= 1'b0;
            end else begin
                r_pending <= w_grant;
                if (w_grant) begin
                    r_issue_cnt <= r_issue_cnt + 3'd1;
                end
                if (w_cap) begin
                    r_recv_cnt <= r_recv_cnt + 3'd1;
                end
                if (w_last) begin
                    r_pc    <= r_fetch_pc;
                    r_inst  <= {mem_rdata_i, r_buf};
                    r_valid <= 1'b1;
                end
                if (w_accept) begin
                    r_fetch_pc  <= r_fetch_pc + 32'd4;
                    r_issue_cnt <= 3'd0;
                    r_recv_cnt  <= 3'd0;
                    r_inst      <= NOP_INST;
                    r_valid     <= 1'b0;
                end
            end
        end
    end

    // Byte buffer carries data only; the counters decide which bytes are meaningful.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            case (r_recv_cnt)
                3'd0:    r_buf[7:0]   <= mem_rdata_i;
                3'd1:    r_buf[15:8]  <= mem_rdata_i;
                3'd2:    r_buf[23:16] <= mem_rdata_i;
                default: r_buf        <= r_buf;
            endcase
        end
    end

    assign mem_req_o    = w_req;
    assign mem_addr_o   = r_fetch_pc + {29'd0, r_issue_cnt};
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;

endmodule
